// File: rtl/lu_req_arbiter.sv
// Round-robin arbiter sharing one flow-table lookup port among NUM_REQ preprocessors.
// Define LU_ARB_TIMEOUT_EN to bound WAIT_ACK to TIMEOUT_CYCLES and count timed-out lookups.
module lu_req_arbiter #(
  parameter int unsigned NUM_REQ               = 4,
  parameter int unsigned OPENFLOW_MATCH_SIZE   = 256,
  parameter int unsigned C_AXIS_LEN_DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT_CYCLES        = 255,
  parameter int unsigned DATA_WIDTH            = 32
) (
  input  logic                                           asclk,
  input  logic                                           areset,
  input  logic [NUM_REQ-1:0]                             s_lu_req,
  input  logic [NUM_REQ*OPENFLOW_MATCH_SIZE-1:0]         s_lu_entry,
  input  logic [NUM_REQ*C_AXIS_LEN_DATA_WIDTH-1:0]       s_lu_len,
  output logic [NUM_REQ-1:0]                             s_lu_ack,
  output logic                                           m_lu_req,
  output logic [OPENFLOW_MATCH_SIZE-1:0]                 m_lu_entry,
  output logic [C_AXIS_LEN_DATA_WIDTH-1:0]               m_lu_len,
  input  logic                                           m_lu_ack,
  output logic [DATA_WIDTH-1:0]                          lu_timeout_cnt,
  output logic [DATA_WIDTH-1:0]                          lu_grant_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned MW    = OPENFLOW_MATCH_SIZE;
  localparam int unsigned LW    = C_AXIS_LEN_DATA_WIDTH;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("lu_req_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("lu_req_arbiter: TIMEOUT_CYCLES must be non-zero");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    ACK      = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic                    m_req_q, m_req_d;
  logic [MW-1:0]           entry_q, entry_d;
  logic [LW-1:0]           len_q, len_d;
  logic [NUM_REQ-1:0]      s_ack_q, s_ack_d;
  logic [DATA_WIDTH-1:0]   gcnt_q, gcnt_d;

`ifdef LU_ARB_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [DATA_WIDTH-1:0]   tcnt_q, tcnt_d;
`endif

  logic [MW-1:0]           entry_arr [NUM_REQ];
  logic [LW-1:0]           len_arr   [NUM_REQ];
  logic [IDX_W-1:0]        win_c;
  logic                    found_c;

  function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
    return (&v) ? v : v + DATA_WIDTH'(1);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign entry_arr[g] = s_lu_entry[g*MW +: MW];
    assign len_arr[g]   = s_lu_len[g*LW +: LW];
  end

  // Round-robin pick: scan from the slot after the last grant, wrapping.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    found_c = 1'b0;
    win_c   = last_q;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found_c && s_lu_req[IDX_W'(idx)]) begin
        found_c = 1'b1;
        win_c   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    m_req_d = m_req_q;
    entry_d = entry_q;
    len_d   = len_q;
    s_ack_d = '0;
    gcnt_d  = gcnt_q;
`ifdef LU_ARB_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    timer_d = timer_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          grant_d = win_c;
          last_d  = win_c;
          entry_d = entry_arr[win_c];
          len_d   = len_arr[win_c];
          m_req_d = 1'b1;
          state_d = WAIT_ACK;
`ifdef LU_ARB_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      WAIT_ACK: begin
        // A table ack in the expiry cycle takes precedence over the timeout.
        if (m_lu_ack) begin
          m_req_d = 1'b0;
          s_ack_d = NUM_REQ'(1) << grant_q;
          state_d = ACK;
        end
`ifdef LU_ARB_TIMEOUT_EN
        else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          m_req_d = 1'b0;
          s_ack_d = NUM_REQ'(1) << grant_q;
          state_d = ACK;
          tcnt_d  = sat_inc(tcnt_q);
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
`endif
      end
      ACK: begin
        gcnt_d  = sat_inc(gcnt_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge asclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      m_req_q <= 1'b0;
      entry_q <= '0;
      len_q   <= '0;
      s_ack_q <= '0;
      gcnt_q  <= '0;
`ifdef LU_ARB_TIMEOUT_EN
      timer_q <= '0;
      tcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      m_req_q <= m_req_d;
      entry_q <= entry_d;
      len_q   <= len_d;
      s_ack_q <= s_ack_d;
      gcnt_q  <= gcnt_d;
`ifdef LU_ARB_TIMEOUT_EN
      timer_q <= timer_d;
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  assign s_lu_ack     = s_ack_q;
  assign m_lu_req     = m_req_q;
  assign m_lu_entry   = entry_q;
  assign m_lu_len     = len_q;
  assign lu_grant_cnt = gcnt_q;
`ifdef LU_ARB_TIMEOUT_EN
  assign lu_timeout_cnt = tcnt_q;
`else
  assign lu_timeout_cnt = '0;
`endif

endmodule

// File: doc/lu_req_arbiter.md
Name: lu_req_arbiter

Overview:
Shares one flow-table lookup port between NUM_REQ pkt_preprocessor instances, one per ingress port group. Each requester presents lu_req/lu_entry/lu_len and holds them until acked. The arbiter grants round-robin, registers the winning entry, drives the flow table's request port, and returns the ack to the winner only. It sits between the preprocessors and the flow_table in openflow_datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
OPENFLOW_MATCH_SIZE, 256, lookup entry width
C_AXIS_LEN_DATA_WIDTH, 16, packet length width
TIMEOUT_CYCLES, 255, WAIT_ACK cycle limit; used only with LU_ARB_TIMEOUT_EN
DATA_WIDTH, 32, counter width

Ports:
asclk  in  1  clock
areset  in  1  asynchronous reset, active-high
s_lu_req  in  NUM_REQ  per-requester request level; bit i = requester i
s_lu_entry  in  NUM_REQ*OPENFLOW_MATCH_SIZE  flat entries; slice i = requester i
s_lu_len  in  NUM_REQ*C_AXIS_LEN_DATA_WIDTH  flat lengths
s_lu_ack  out  NUM_REQ  one-cycle ack pulse to the granted requester
m_lu_req  out  1  request to flow_table
m_lu_entry  out  OPENFLOW_MATCH_SIZE  registered granted entry
m_lu_len  out  C_AXIS_LEN_DATA_WIDTH  registered granted length
m_lu_ack  in  1  flow_table ack, one-cycle pulse
lu_timeout_cnt  out  DATA_WIDTH  count of timed-out lookups
lu_grant_cnt  out  DATA_WIDTH  count of completed grants (acked or timed out)

Behaviour:
- Reset (async, areset=1): state=IDLE, last_grant=NUM_REQ-1, s_lu_ack=0, m_lu_req=0, m_lu_entry=0, m_lu_len=0, both counters=0. Any in-flight lookup is dropped and no ack is issued.
- Requester contract: hold s_lu_req[i] and its entry/len stable until s_lu_ack[i]; drop the request in the cycle after the ack.
- States:
  - IDLE: if any s_lu_req bit is set, pick the first set bit scanning last_grant+1, +2, ... mod NUM_REQ. Latch grant index, entry, and len. Update last_grant. Go to WAIT_ACK. m_lu_req=1 from the next cycle (1-cycle request latency).
  - WAIT_ACK: m_lu_req=1 with entry/len stable. On m_lu_ack=1: m_lu_req=0 next cycle, s_lu_ack[grant]=1 next cycle, go to ACK. m_lu_ack arriving in any other state is ignored.
  - ACK: s_lu_ack[grant] high for exactly this cycle. No arbitration in this cycle, so a requester still asserting req is not re-granted. lu_grant_cnt++. Go to IDLE.
- Throughput: at most one lookup per 3 cycles plus flow-table latency. The m_lu_ack→s_lu_ack latency is 1 cycle.
- Fairness: the requester just granted has lowest priority in the next arbitration. With all requesters active, the grant order is strictly cyclic.
- s_lu_ack is one-hot or zero, never multi-hot. Requests that drop while not granted are simply skipped.
- Counters saturate at all-ones and do not wrap.
- Changes to s_lu_entry after the grant do not affect m_lu_entry.

Optional Feature:
Macro LU_ARB_TIMEOUT_EN.
- Defined: a timer clears on WAIT_ACK entry and increments each WAIT_ACK cycle. When it reaches TIMEOUT_CYCLES with no m_lu_ack, m_lu_req drops, the FSM goes to ACK (the requester is released with an ack), and lu_timeout_cnt increments (saturating).
- If m_lu_ack and expiry coincide, the ack wins and no timeout is counted.
- Not defined: WAIT_ACK waits indefinitely, and lu_timeout_cnt is tied to 0.

Test Plan:
1. Reset deasserts; s_lu_req=4'b0100, entry=E2, len=64; m_lu_ack pulses 5 cycles after m_lu_req rises. Expect: m_lu_req 1 cycle after req; m_lu_entry=E2, m_lu_len=64; s_lu_ack=4'b0100 for exactly 1 cycle, 1 cycle after m_lu_ack; lu_grant_cnt=1.
2. All four requesters assert simultaneously, and each re-asserts immediately after its ack, with flow-table ack latency 2. Expect grant order 0,1,2,3,0,1; s_lu_ack never multi-hot; no requester granted twice in a row.
3. Requesters 1 and 3 are active, last_grant=1. Expect 3 granted next, then 1. After 3 drops, 1 is granted twice consecutively with no idle grant to others.
4. m_lu_ack pulses while in IDLE with no requests. Expect no s_lu_ack, counters unchanged, state IDLE.
5. With LU_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=10, m_lu_ack is never asserted. Expect m_lu_req high 10 cycles then low, s_lu_ack pulse to the granted requester, lu_timeout_cnt=1. Repeat with m_lu_ack on cycle 10: lu_timeout_cnt stays 1.
6. Assert areset in WAIT_ACK (mid-lookup). Expect m_lu_req=0 and s_lu_ack=0 immediately, counters 0, and after release requester 0 wins when all request.
